seg7_scan_driver: RTL and testbench
===================================

// Module: seg7_scan_driver
// PURPOSE
//  Downstream display stage of the verily top level. Takes a 16-bit hex value from the
//  core over a valid/ready handshake and drives the 4-digit multiplexed 7-segment display.
//  Pins driven: o_seg7[6:0] and o_seg7_nSel[3:0].
//  Double-buffers the value, so updates commit only at frame boundaries (no tearing).
//  Inserts dead time between digits to suppress ghosting.
// PARAMETERS
//  CLKS_PER_DIGIT  50000  clocks per digit slot; legal range >= 4
//  DEAD_CYCLES     64     clocks at the start of each slot with all digits off; must be < CLKS_PER_DIGIT
//  SEG_ACTIVE_LOW  1      1: segment on = 0 on o_seg7; 0: segment on = 1
// PORTS
//  i_clk        in   1   system clock, all logic on rising edge
//  i_nReset     in   1   synchronous reset, active low
//  i_valid      in   1   upstream presents i_value/i_blank/i_lzs
//  o_ready      out  1   shadow buffer empty; transfer when i_valid && o_ready
//  i_value      in   16  4 hex nibbles; [3:0] = digit 0 (rightmost)
//  i_blank      in   4   per-digit force-dark mask, bit n = digit n
//  i_lzs        in   1   leading-zero suppression enable
//  o_seg7       out  7   segments {g,f,e,d,c,b,a}, polarity per SEG_ACTIVE_LOW
//  o_seg7_nSel  out  4   digit enables, active low; bit n = digit n
//  o_frame      out  1   one-cycle pulse: frame boundary reached (commit point)
// BEHAVIOUR
//  Reset (i_nReset=0 at edge): clears all state.
//   - Slot counter = 0, digit index = 0.
//   - Shadow empty: o_ready=1. Active value = 0, active blank = 4'b1111 (dark until first load).
//   - o_seg7_nSel = 4'b1111; o_seg7 = all segments off; o_frame = 0.
//   - Reset mid-frame or mid-handshake discards the pending shadow; takes effect the same edge.
//  Scan:
//   - cnt runs 0..CLKS_PER_DIGIT-1, then wraps. On wrap, digit advances 0->1->2->3->0.
//   - cnt < DEAD_CYCLES: nSel = 1111, segments off.
//   - Otherwise: nSel[digit] = 0, others 1; segments = decode(active nibble[digit]).
//   - All outputs are registered: pins reflect the cnt/digit state with one clock of latency.
//  Decode (active-high a..g, hex): 0:3F 1:06 2:5B 3:4F 4:66 5:6D 6:7D 7:07
//   8:7F 9:6F A:77 b:7C C:39 d:5E E:79 F:71. When SEG_ACTIVE_LOW=1, o_seg7 = ~code.
//  Dark digit: nSel stays 1 for the whole slot; the slot timing is unchanged.
//   - A digit is dark if its active blank bit is set, or if it is suppressed by LZS.
//   - LZS (latched with the value): digits 3,2,1 are suppressed while the nibble and all higher nibbles are 0.
//   - Digit 0 is never suppressed.
//  Handshake:
//   - On i_valid && o_ready, the shadow captures {i_value, i_blank, i_lzs}; o_ready=0 from the next cycle.
//   - i_valid while o_ready=0 is ignored; upstream holds until ready.
//  Frame boundary = edge with digit==3 && cnt==CLKS_PER_DIGIT-1. On that edge:
//   - If the shadow is full: active <= shadow, shadow empties, o_ready=1 next cycle.
//   - o_frame=1 for the next cycle, whether or not a commit happened.
//  Simultaneous accept and boundary on the same edge: the value enters the shadow.
//   - It commits at the following boundary, never at the same one.
//  Active value is never modified except at a boundary or by reset.
// TESTING (CLKS_PER_DIGIT=8, DEAD_CYCLES=2, SEG_ACTIVE_LOW=1, 2ns clock)
//  1 Reset, no load, run 3 frames -> nSel=1111 and seg=7F throughout; o_ready=1; o_frame every 32 clks.
//  2 Load 16'h1234, blank=0, lzs=0; after next o_frame, per slot:
//    - digit0: nSel=1110, seg=19
//    - digit1: nSel=1101, seg=30
//    - digit2: nSel=1011, seg=24
//    - digit3: nSel=0111, seg=79
//  3 Dead time: check the first 2 clocks of every slot in test 2 -> nSel=1111, seg=7F; the remaining 6 clocks show the digit.
//  4 Backpressure: valid 16'hAAAA accepted, then valid 16'hBBBB held ->
//    - o_ready=0 until the boundary; AAAA displayed in the next frame.
//    - BBBB accepted after ready returns to 1; BBBB displayed in the frame after that.
//  5 LZS: 16'h0070, lzs=1 -> digits 3,2 dark; digit1 seg=78 (7); digit0 seg=40 (0).
//    - 16'h0000 -> only digit0 lit, seg=40.
//  6 Reset asserted mid-slot with the shadow full -> next cycle nSel=1111, o_ready=1.
//    - Display stays dark until a new load commits.

Source files
------------

// File: rtl/seg7_scan_driver.sv
`default_nettype none
// ============================================================================
// Module      : seg7_scan_driver
// Description : 4-digit multiplexed 7-segment scan driver with valid/ready
//               input, double-buffered value (commit at frame boundary),
//               per-digit blanking, leading-zero suppression and dead time
//               at the start of each digit slot.
// Revision    : 1.0 - initial release
// ============================================================================
module seg7_scan_driver #(
  parameter int CLKS_PER_DIGIT = 50000,
  parameter int DEAD_CYCLES    = 64,
  parameter bit SEG_ACTIVE_LOW = 1'b1
) (
  input  logic        i_clk,
  input  logic        i_nReset,
  input  logic        i_valid,
  output logic        o_ready,
  input  logic [15:0] i_value,
  input  logic [3:0]  i_blank,
  input  logic        i_lzs,
  output logic [6:0]  o_seg7,
  output logic [3:0]  o_seg7_nSel,
  output logic        o_frame
);

  localparam int               c_CNT_W   = (CLKS_PER_DIGIT > 1) ? $clog2(CLKS_PER_DIGIT) : 1;
  localparam logic [c_CNT_W-1:0] c_CNT_MAX = c_CNT_W'(CLKS_PER_DIGIT - 1);
  localparam logic [c_CNT_W-1:0] c_DEAD    = c_CNT_W'(DEAD_CYCLES);
  localparam logic [6:0]       c_SEG_OFF = SEG_ACTIVE_LOW ? 7'h7F : 7'h00;

  // Scan position
  logic [c_CNT_W-1:0] cnt_q, cnt_d;
  logic [1:0]         digit_q, digit_d;

  // Shadow (pending) buffer
  logic [15:0] shd_val_q, shd_val_d;
  logic [3:0]  shd_blank_q, shd_blank_d;
  logic        shd_lzs_q, shd_lzs_d;
  logic        shd_full_q, shd_full_d;

  // Active (displayed) buffer
  logic [15:0] act_val_q, act_val_d;
  logic [3:0]  act_blank_q, act_blank_d;
  logic        act_lzs_q, act_lzs_d;

  // Registered pins
  logic [6:0] seg_q, seg_d;
  logic [3:0] nsel_q, nsel_d;
  logic       frame_q, frame_d;

  logic       w_wrap;
  logic       w_boundary;
  logic       w_accept;
  logic [3:0] w_nib;
  logic [3:0] w_supp;
  logic [3:0] w_dark;
  logic       w_lit;
  logic [6:0] w_code;

  assign w_wrap     = (cnt_q == c_CNT_MAX);
  assign w_boundary = w_wrap && (digit_q == 2'd3);
  assign w_accept   = i_valid && !shd_full_q;

  // Slot counter and digit index advance
  always_comb begin
    cnt_d   = cnt_q + 1'b1;
    digit_d = digit_q;
    if (w_wrap) begin
      cnt_d   = '0;
      digit_d = digit_q + 2'd1;
    end
  end

  // Shadow capture on handshake, shadow-to-active commit at frame boundary.
  // Accept needs an empty shadow and commit needs a full one, so they never
  // collide; a value accepted on a boundary edge waits for the next boundary.
  always_comb begin
    shd_val_d   = shd_val_q;
    shd_blank_d = shd_blank_q;
    shd_lzs_d   = shd_lzs_q;
    shd_full_d  = shd_full_q;
    act_val_d   = act_val_q;
    act_blank_d = act_blank_q;
    act_lzs_d   = act_lzs_q;
    if (w_boundary && shd_full_q) begin
      act_val_d   = shd_val_q;
      act_blank_d = shd_blank_q;
      act_lzs_d   = shd_lzs_q;
      shd_full_d  = 1'b0;
    end
    if (w_accept) begin
      shd_val_d   = i_value;
      shd_blank_d = i_blank;
      shd_lzs_d   = i_lzs;
      shd_full_d  = 1'b1;
    end
  end

  // Nibble select, dark-digit mask (blank or leading-zero) and hex decode
  always_comb begin
    w_nib = 4'h0;
    case (digit_q)
      2'd0:    w_nib = act_val_q[3:0];
      2'd1:    w_nib = act_val_q[7:4];
      2'd2:    w_nib = act_val_q[11:8];
      default: w_nib = act_val_q[15:12];
    endcase
    w_supp[3] = act_lzs_q && (act_val_q[15:12] == 4'h0);
    w_supp[2] = w_supp[3] && (act_val_q[11:8] == 4'h0);
    w_supp[1] = w_supp[2] && (act_val_q[7:4] == 4'h0);
    w_supp[0] = 1'b0;
    w_dark    = act_blank_q | w_supp;
    w_lit     = (cnt_q >= c_DEAD) && !w_dark[digit_q];
    w_code    = 7'h00;
    case (w_nib)
      4'h0: w_code = 7'h3F;
      4'h1: w_code = 7'h06;
      4'h2: w_code = 7'h5B;
      4'h3: w_code = 7'h4F;
      4'h4: w_code = 7'h66;
      4'h5: w_code = 7'h6D;
      4'h6: w_code = 7'h7D;
      4'h7: w_code = 7'h07;
      4'h8: w_code = 7'h7F;
      4'h9: w_code = 7'h6F;
      4'hA: w_code = 7'h77;
      4'hB: w_code = 7'h7C;
      4'hC: w_code = 7'h39;
      4'hD: w_code = 7'h5E;
      4'hE: w_code = 7'h79;
      default: w_code = 7'h71;
    endcase
  end

  // Next pin values derived from the current scan position
  always_comb begin
    seg_d   = c_SEG_OFF;
    nsel_d  = 4'b1111;
    frame_d = w_boundary;
    if (w_lit) begin
      seg_d           = SEG_ACTIVE_LOW ? ~w_code : w_code;
      nsel_d[digit_q] = 1'b0;
    end
  end

  // State and output registers with synchronous active-low reset
  always_ff @(posedge i_clk) begin
    if (!i_nReset) begin
      cnt_q       <= '0;
      digit_q     <= 2'd0;
      shd_val_q   <= 16'h0000;
      shd_blank_q <= 4'b0000;
      shd_lzs_q   <= 1'b0;
      shd_full_q  <= 1'b0;
      act_val_q   <= 16'h0000;
      act_blank_q <= 4'b1111;
      act_lzs_q   <= 1'b0;
      seg_q       <= c_SEG_OFF;
      nsel_q      <= 4'b1111;
      frame_q     <= 1'b0;
    end else begin
      cnt_q       <= cnt_d;
      digit_q     <= digit_d;
      shd_val_q   <= shd_val_d;
      shd_blank_q <= shd_blank_d;
      shd_lzs_q   <= shd_lzs_d;
      shd_full_q  <= shd_full_d;
      act_val_q   <= act_val_d;
      act_blank_q <= act_blank_d;
      act_lzs_q   <= act_lzs_d;
      seg_q       <= seg_d;
      nsel_q      <= nsel_d;
      frame_q     <= frame_d;
    end
  end

  assign o_ready     = !shd_full_q;
  assign o_seg7      = seg_q;
  assign o_seg7_nSel = nsel_q;
  assign o_frame     = frame_q;

endmodule
`default_nettype wire

// File: tb/tb_seg7_scan_driver.sv
`default_nettype none
// ============================================================================
// Module      : tb_seg7_scan_driver
// Description : Directed self-checking bench for seg7_scan_driver
//               (8 clocks per digit, 2 dead clocks, active-low segments).
// Revision    : 1.0 - initial release
// ============================================================================
module tb_seg7_scan_driver;

  logic        clk = 1'b0;
  logic        i_nReset;
  logic        i_valid;
  logic        o_ready;
  logic [15:0] i_value;
  logic [3:0]  i_blank;
  logic        i_lzs;
  logic [6:0]  o_seg7;
  logic [3:0]  o_seg7_nSel;
  logic        o_frame;

  int n_chk  = 0;
  int n_pass = 0;

  always #1 clk = ~clk;

  seg7_scan_driver #(
    .CLKS_PER_DIGIT(8),
    .DEAD_CYCLES   (2),
    .SEG_ACTIVE_LOW(1'b1)
  ) u_dut (
    .i_clk      (clk),
    .i_nReset   (i_nReset),
    .i_valid    (i_valid),
    .o_ready    (o_ready),
    .i_value    (i_value),
    .i_blank    (i_blank),
    .i_lzs      (i_lzs),
    .o_seg7     (o_seg7),
    .o_seg7_nSel(o_seg7_nSel),
    .o_frame    (o_frame)
  );

  task automatic check(input string tag, input logic [15:0] got, input logic [15:0] exp);
    n_chk++;
    if (got !== exp) $display("FAIL %s: got %h expected %h", tag, got, exp);
    else n_pass++;
  endtask

  // Advance (on negedges) until o_frame is seen, bounded.
  task automatic wait_frame();
    logic seen;
    seen = 1'b0;
    for (int k = 0; k < 40; k++) begin
      @(negedge clk);
      if (o_frame === 1'b1) begin
        seen = 1'b1;
        break;
      end
    end
    if (!seen) check("frame_timeout", 16'h0, 16'h1);
  endtask

  // Offer a value at the current negedge; returns one negedge after acceptance.
  task automatic send(input logic [15:0] v, input logic [3:0] b, input logic l);
    logic done;
    done    = 1'b0;
    i_valid = 1'b1;
    i_value = v;
    i_blank = b;
    i_lzs   = l;
    for (int k = 0; k < 80; k++) begin
      if (o_ready === 1'b1) begin
        @(posedge clk);
        done = 1'b1;
        break;
      end
      @(negedge clk);
    end
    if (!done) check("send_timeout", 16'h0, 16'h1);
    @(negedge clk);
    i_valid = 1'b0;
  endtask

  // Called right after an o_frame sample: checks the 32 samples of the
  // following frame and ends on the next o_frame sample.
  task automatic check_frame(input logic [6:0] s0, input logic [6:0] s1,
                             input logic [6:0] s2, input logic [6:0] s3,
                             input logic [3:0] dark);
    logic [6:0] es;
    logic [3:0] en;
    int d;
    int p;
    for (int i = 0; i < 32; i++) begin
      @(negedge clk);
      if (i == 0) i_valid = 1'b0;
      d  = i / 8;
      p  = i % 8;
      en = 4'b1111;
      es = 7'h7F;
      if (p >= 2 && !dark[d]) begin
        en[d] = 1'b0;
        case (d)
          0:       es = s0;
          1:       es = s1;
          2:       es = s2;
          default: es = s3;
        endcase
      end
      check("slot", {5'b0, o_seg7_nSel, o_seg7}, {5'b0, en, es});
      check("frame", {15'b0, o_frame}, (i == 31) ? 16'h1 : 16'h0);
    end
  endtask

  initial begin
    i_nReset = 1'b0;
    i_valid  = 1'b0;
    i_value  = 16'h0;
    i_blank  = 4'h0;
    i_lzs    = 1'b0;
    repeat (2) @(negedge clk);

    // Reset state
    check("rst_nsel",  {12'b0, o_seg7_nSel}, 16'h000F);
    check("rst_seg",   {9'b0, o_seg7},       16'h007F);
    check("rst_ready", {15'b0, o_ready},     16'h0001);
    check("rst_frame", {15'b0, o_frame},     16'h0000);
    i_nReset = 1'b1;

    // 1: no load, three dark frames, frame pulse every 32 clocks
    wait_frame();
    repeat (3) check_frame(7'h7F, 7'h7F, 7'h7F, 7'h7F, 4'b1111);
    check("idle_ready", {15'b0, o_ready}, 16'h0001);

    // 2/3: 1234, no blank, no LZS
    send(16'h1234, 4'b0000, 1'b0);
    check("shadow_full", {15'b0, o_ready}, 16'h0000);
    wait_frame();
    check("commit_ready", {15'b0, o_ready}, 16'h0001);
    check_frame(7'h19, 7'h30, 7'h24, 7'h79, 4'b0000);

    // Per-digit blank: digit 1 dark
    send(16'h1234, 4'b0010, 1'b0);
    wait_frame();
    check_frame(7'h19, 7'h30, 7'h24, 7'h79, 4'b0010);

    // 4: backpressure
    send(16'hAAAA, 4'b0000, 1'b0);
    i_valid = 1'b1;
    i_value = 16'hBBBB;
    i_blank = 4'b0000;
    i_lzs   = 1'b0;
    check("bp_ready0", {15'b0, o_ready}, 16'h0000);
    repeat (5) @(negedge clk);
    check("bp_ready0_hold", {15'b0, o_ready}, 16'h0000);
    wait_frame();
    check("bp_ready1", {15'b0, o_ready}, 16'h0001);
    check_frame(7'h08, 7'h08, 7'h08, 7'h08, 4'b0000);
    check("bp_ready_b", {15'b0, o_ready}, 16'h0001);
    check_frame(7'h03, 7'h03, 7'h03, 7'h03, 4'b0000);

    // 5: leading-zero suppression
    send(16'h0070, 4'b0000, 1'b1);
    wait_frame();
    check_frame(7'h40, 7'h78, 7'h7F, 7'h7F, 4'b1100);
    send(16'h0000, 4'b0000, 1'b1);
    wait_frame();
    check_frame(7'h40, 7'h7F, 7'h7F, 7'h7F, 4'b1110);

    // 6: reset mid-slot with the shadow full
    send(16'h5555, 4'b0000, 1'b0);
    repeat (10) @(negedge clk);
    check("pre_rst_ready", {15'b0, o_ready}, 16'h0000);
    i_nReset = 1'b0;
    @(negedge clk);
    check("mid_rst_nsel",  {12'b0, o_seg7_nSel}, 16'h000F);
    check("mid_rst_seg",   {9'b0, o_seg7},       16'h007F);
    check("mid_rst_ready", {15'b0, o_ready},     16'h0001);
    i_nReset = 1'b1;
    wait_frame();
    check_frame(7'h7F, 7'h7F, 7'h7F, 7'h7F, 4'b1111);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
`default_nettype wire
